// File: rtl/fir_interp_pkg.sv
// Shared fixed-point globals for the signal chain: sample width, quantization
// scale and the rounding multiply used by every FIR stage.
package fir_interp_pkg;

    localparam int DATA_SIZE = 32;
    localparam int BITS      = 14;
    localparam int QUANT_VAL = 1 << BITS;

    typedef logic signed [DATA_SIZE-1:0] sample_t;

    // Full-precision product, rounded half-up at the binary point, then wrapped back to DATA_SIZE.
    function automatic sample_t MULTIPLY_ROUNDING(input sample_t a, input sample_t b);
        logic signed [2*DATA_SIZE-1:0] product;
        product = a * b;
        product = product + (2*DATA_SIZE)'(QUANT_VAL / 2);
        return sample_t'(product >>> BITS);
    endfunction

endpackage

// File: rtl/fir_interp_if.sv
// FIFO-side handshake bundle of the interpolating FIR: show-ahead input FIFO
// read port and output FIFO write port.
interface fir_interp_if;
    import fir_interp_pkg::*;

    logic [DATA_SIZE-1:0] x_in_dout;
    logic                 x_in_empty;
    logic                 x_in_rd_en;
    logic                 y_out_full;
    logic                 y_out_wr_en;
    logic [DATA_SIZE-1:0] y_out_din;

    modport master (
        input  x_in_dout,
        input  x_in_empty,
        output x_in_rd_en,
        input  y_out_full,
        output y_out_wr_en,
        output y_out_din
    );

    modport slave (
        output x_in_dout,
        output x_in_empty,
        input  x_in_rd_en,
        output y_out_full,
        input  y_out_wr_en,
        input  y_out_din
    );

endinterface

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input sample in, INTERPOLATION filtered samples out.
// Define FIR_INTERP_GAIN_EN to scale each output by INTERPOLATION (left shift, wrapping).
module fir_interp
    import fir_interp_pkg::*;
#(
    parameter int NUM_TAPS      = 32,
    parameter int INTERPOLATION = 8,
    parameter logic [0:NUM_TAPS-1][DATA_SIZE-1:0] COEFFICIENTS = '0
) (
    input logic          clock,
    input logic          reset_n,
    fir_interp_if.master bus
);

    localparam int TAPS_PER_PHASE = NUM_TAPS / INTERPOLATION;
    localparam int LOG2_L         = $clog2(INTERPOLATION);
    localparam int KW             = (TAPS_PER_PHASE > 1) ? $clog2(TAPS_PER_PHASE) : 1;
    localparam int PW             = (LOG2_L > 0) ? LOG2_L : 1;

    if ((INTERPOLATION < 2) || ((INTERPOLATION & (INTERPOLATION - 1)) != 0) ||
        ((NUM_TAPS % INTERPOLATION) != 0)) begin : g_bad_params
        $error("fir_interp: INTERPOLATION must be a power of two >= 2 that divides NUM_TAPS");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    sample_t [TAPS_PER_PHASE-1:0] hist_q, hist_d;
    sample_t                      sum_q, sum_d;
    sample_t                      tap_value_q, tap_value_d;
    logic [KW-1:0]                k_q, k_d;
    logic [PW-1:0]                phase_q, phase_d;

    int      coeff_idx;
    sample_t coeff;
    sample_t product;
    sample_t next_tap;
    sample_t out_value;

    logic                 rd_en;
    logic                 wr_en;
    logic [DATA_SIZE-1:0] din;

    assign coeff_idx = int'(k_q) * INTERPOLATION + int'(phase_q);

    // Phase p of tap k lives at prototype index k*L + p.
    always_comb begin
        coeff = '0;
        for (int j = 0; j < NUM_TAPS; j++) begin
            if (j == coeff_idx) begin
                coeff = sample_t'(COEFFICIENTS[j]);
            end
        end
    end

    always_comb begin
        next_tap = '0;
        for (int j = 1; j < TAPS_PER_PHASE; j++) begin
            if (j == int'(k_q) + 1) begin
                next_tap = hist_q[j];
            end
        end
    end

    assign product = MULTIPLY_ROUNDING(tap_value_q, coeff);

`ifdef FIR_INTERP_GAIN_EN
    assign out_value = sum_q << LOG2_L;
`else
    assign out_value = sum_q;
`endif

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        sum_d       = sum_q;
        tap_value_d = tap_value_q;
        k_d         = k_q;
        phase_d     = phase_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        din         = '0;

        case (state_q)
            S_IDLE: begin
                if (!bus.x_in_empty) begin
                    rd_en = 1'b1;
                    for (int j = TAPS_PER_PHASE - 1; j > 0; j--) begin
                        hist_d[j] = hist_q[j-1];
                    end
                    hist_d[0]   = sample_t'(bus.x_in_dout);
                    tap_value_d = sample_t'(bus.x_in_dout);
                    phase_d     = '0;
                    k_d         = '0;
                    sum_d       = '0;
                    state_d     = S_MAC;
                end
            end

            S_MAC: begin
                sum_d       = sum_q + product;
                tap_value_d = next_tap;
                // k wraps to 0 on the last tap; S_OUT would clear it anyway.
                if (k_q == KW'(TAPS_PER_PHASE - 1)) begin
                    k_d     = '0;
                    state_d = S_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            S_OUT: begin
                if (!bus.y_out_full) begin
                    wr_en       = 1'b1;
                    din         = out_value;
                    sum_d       = '0;
                    k_d         = '0;
                    tap_value_d = hist_q[0];
                    if (phase_q == PW'(INTERPOLATION - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                        state_d = S_MAC;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            hist_q      <= '0;
            sum_q       <= '0;
            tap_value_q <= '0;
            k_q         <= '0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            tap_value_q <= tap_value_d;
            k_q         <= k_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.x_in_rd_en  = rd_en;
    assign bus.y_out_wr_en = wr_en;
    assign bus.y_out_din   = din;

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: two instances (ramp taps and flat taps) fed from
// queue-modelled show-ahead FIFOs, checking values, timing, stalls and reset.
module tb_fir_interp;
    import fir_interp_pkg::*;

    localparam int NT = 32;
    localparam int L  = 8;

`ifdef FIR_INTERP_GAIN_EN
    localparam int GAIN_SHIFT = 3;
`else
    localparam int GAIN_SHIFT = 0;
`endif

    localparam logic [DATA_SIZE-1:0] Q = DATA_SIZE'(QUANT_VAL);

    function automatic logic [0:NT-1][DATA_SIZE-1:0] ramp_coeffs();
        logic [0:NT-1][DATA_SIZE-1:0] r;
        for (int j = 0; j < NT; j++) begin
            r[j] = DATA_SIZE'(j * QUANT_VAL);
        end
        return r;
    endfunction

    localparam logic [0:NT-1][DATA_SIZE-1:0] RAMP = ramp_coeffs();
    localparam logic [0:NT-1][DATA_SIZE-1:0] FLAT = {NT{Q}};

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    fir_interp_if bus_a ();
    fir_interp_if bus_b ();

    fir_interp #(.NUM_TAPS(NT), .INTERPOLATION(L), .COEFFICIENTS(RAMP)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    fir_interp #(.NUM_TAPS(NT), .INTERPOLATION(L), .COEFFICIENTS(FLAT)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DATA_SIZE-1:0] qa[$];
    logic [DATA_SIZE-1:0] qb[$];
    logic [DATA_SIZE-1:0] outa[$];
    logic [DATA_SIZE-1:0] outb[$];
    int                   rd_cyc_a[$];
    int                   wr_cyc_a[$];

    logic                 full_a = 1'b0;
    logic                 last_rd_a;
    logic                 last_wr_a;
    logic [DATA_SIZE-1:0] last_din_a;

    // Ramp taps with an impulse: output n of the burst sequence is n*Q, then zeros.
    function automatic logic [DATA_SIZE-1:0] impulse_value(input int n);
        logic [DATA_SIZE-1:0] v;
        v = '0;
        if (n < 32) begin
            v = DATA_SIZE'(n * QUANT_VAL);
        end
        return v << GAIN_SHIFT;
    endfunction

    task automatic step();
        @(negedge clock);
        bus_a.y_out_full = full_a;
        bus_a.x_in_empty = (qa.size() == 0);
        if (qa.size() == 0) bus_a.x_in_dout = '0;
        else                bus_a.x_in_dout = qa[0];
        bus_b.y_out_full = 1'b0;
        bus_b.x_in_empty = (qb.size() == 0);
        if (qb.size() == 0) bus_b.x_in_dout = '0;
        else                bus_b.x_in_dout = qb[0];
        #1;
        last_rd_a  = bus_a.x_in_rd_en;
        last_wr_a  = bus_a.y_out_wr_en;
        last_din_a = bus_a.y_out_din;
        if (bus_a.x_in_rd_en === 1'b1) begin
            rd_cyc_a.push_back(cyc);
            if (qa.size() != 0) void'(qa.pop_front());
        end
        if (bus_a.y_out_wr_en === 1'b1) begin
            outa.push_back(bus_a.y_out_din);
            wr_cyc_a.push_back(cyc);
        end
        if (bus_b.x_in_rd_en === 1'b1 && qb.size() != 0) void'(qb.pop_front());
        if (bus_b.y_out_wr_en === 1'b1) outb.push_back(bus_b.y_out_din);
        cyc++;
    endtask

    task automatic run_until(input int want_a, input int want_b, input int budget);
        int n;
        n = 0;
        while ((outa.size() < want_a || outb.size() < want_b) && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic clear_a();
        outa.delete();
        rd_cyc_a.delete();
        wr_cyc_a.delete();
    endtask

    task automatic push_impulse();
        qa.push_back(Q);
        repeat (4) qa.push_back('0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus_a.x_in_rd_en !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", bus_a.x_in_rd_en);
        end
        checks++;
        if (bus_a.y_out_wr_en !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus_a.y_out_wr_en);
        end
        checks++;
        if (bus_a.y_out_din !== '0) begin
            errors++; $display("[TB] FAIL reset_din: got %0d expected 0", bus_a.y_out_din);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (last_rd_a !== 1'b0 || last_wr_a !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset: rd=%b wr=%b expected 0 0", last_rd_a, last_wr_a);
        end
    endtask

    task automatic test_dc();
        outb.delete();
        repeat (6) qb.push_back(Q);
        run_until(0, 48, 400);
        checks++;
        if (outb.size() != 48) begin
            errors++; $display("[TB] FAIL dc_count: got %0d expected 48", outb.size());
        end
        for (int n = 0; n < outb.size() && n < 48; n++) begin
            int filled;
            logic [DATA_SIZE-1:0] exp_v;
            filled = (n / 8 + 1 > 4) ? 4 : n / 8 + 1;
            exp_v  = DATA_SIZE'(filled * QUANT_VAL) << GAIN_SHIFT;
            checks++;
            if (outb[n] !== exp_v) begin
                errors++; $display("[TB] FAIL dc[%0d]: got %0d expected %0d", n, outb[n], exp_v);
            end
        end
    endtask

    task automatic test_impulse();
        clear_a();
        push_impulse();
        run_until(40, 0, 400);
        checks++;
        if (outa.size() != 40) begin
            errors++; $display("[TB] FAIL impulse_count: got %0d expected 40", outa.size());
        end
        for (int n = 0; n < outa.size() && n < 40; n++) begin
            checks++;
            if (outa[n] !== impulse_value(n)) begin
                errors++; $display("[TB] FAIL impulse[%0d]: got %0d expected %0d", n, outa[n], impulse_value(n));
            end
        end
    endtask

    task automatic test_throughput();
        int bad_gap;
        clear_a();
        repeat (3) qa.push_back('0);
        run_until(24, 0, 200);
        checks++;
        if (rd_cyc_a.size() != 3) begin
            errors++; $display("[TB] FAIL thr_reads: got %0d expected 3", rd_cyc_a.size());
        end
        for (int r = 1; r < rd_cyc_a.size(); r++) begin
            checks++;
            if (rd_cyc_a[r] - rd_cyc_a[r-1] != 41) begin
                errors++; $display("[TB] FAIL thr_read_gap[%0d]: got %0d expected 41", r, rd_cyc_a[r] - rd_cyc_a[r-1]);
            end
        end
        for (int r = 0; r < rd_cyc_a.size() && r * 8 < wr_cyc_a.size(); r++) begin
            checks++;
            if (wr_cyc_a[r*8] - rd_cyc_a[r] != 5) begin
                errors++; $display("[TB] FAIL thr_first_write[%0d]: got %0d expected 5", r, wr_cyc_a[r*8] - rd_cyc_a[r]);
            end
        end
        bad_gap = 0;
        for (int m = 1; m < wr_cyc_a.size(); m++) begin
            if ((m % 8) != 0 && wr_cyc_a[m] - wr_cyc_a[m-1] != 5) bad_gap++;
        end
        checks++;
        if (bad_gap != 0 || wr_cyc_a.size() != 24) begin
            errors++; $display("[TB] FAIL thr_write_spacing: bad gaps %0d writes %0d expected 0 and 24", bad_gap, wr_cyc_a.size());
        end
    endtask

    task automatic test_backpressure();
        int n;
        int hold_activity;
        bit stalled;
        clear_a();
        push_impulse();
        n = 0;
        hold_activity = 0;
        stalled = 1'b0;
        while (outa.size() < 40 && n < 600) begin
            if (outa.size() == 2 && !stalled) begin
                stalled = 1'b1;
                full_a  = 1'b1;
                repeat (20) begin
                    step();
                    n++;
                    if (last_wr_a !== 1'b0 || last_rd_a !== 1'b0 || last_din_a !== '0) hold_activity++;
                end
                full_a = 1'b0;
            end else begin
                step();
                n++;
            end
        end
        checks++;
        if (hold_activity != 0) begin
            errors++; $display("[TB] FAIL bp_hold_quiet: got %0d active cycles expected 0", hold_activity);
        end
        checks++;
        if (wr_cyc_a.size() >= 3 && wr_cyc_a[2] - wr_cyc_a[1] != 21) begin
            errors++; $display("[TB] FAIL bp_stall_gap: got %0d expected 21", wr_cyc_a[2] - wr_cyc_a[1]);
        end else if (wr_cyc_a.size() < 3) begin
            errors++; $display("[TB] FAIL bp_stall_gap: got %0d writes expected at least 3", wr_cyc_a.size());
        end
        checks++;
        if (rd_cyc_a.size() != 5 || wr_cyc_a.size() != 8 * rd_cyc_a.size()) begin
            errors++; $display("[TB] FAIL bp_counts: reads %0d writes %0d expected 5 and 40", rd_cyc_a.size(), wr_cyc_a.size());
        end
        for (int k = 0; k < outa.size() && k < 40; k++) begin
            checks++;
            if (outa[k] !== impulse_value(k)) begin
                errors++; $display("[TB] FAIL bp[%0d]: got %0d expected %0d", k, outa[k], impulse_value(k));
            end
        end
    endtask

    task automatic test_starvation();
        int bad_rd, bad_wr, bad_din;
        clear_a();
        qa.push_back(Q);
        run_until(8, 0, 100);
        bad_rd = 0; bad_wr = 0; bad_din = 0;
        repeat (100) begin
            step();
            if (last_rd_a !== 1'b0) bad_rd++;
            if (last_wr_a !== 1'b0) bad_wr++;
            if (last_din_a !== '0) bad_din++;
        end
        checks++;
        if (bad_rd != 0) begin
            errors++; $display("[TB] FAIL starve_rd_en: got %0d active cycles expected 0", bad_rd);
        end
        checks++;
        if (bad_wr != 0) begin
            errors++; $display("[TB] FAIL starve_wr_en: got %0d active cycles expected 0", bad_wr);
        end
        checks++;
        if (bad_din != 0) begin
            errors++; $display("[TB] FAIL starve_din: got %0d nonzero cycles expected 0", bad_din);
        end
        repeat (3) qa.push_back('0);
        run_until(32, 0, 300);
        checks++;
        if (outa.size() != 32) begin
            errors++; $display("[TB] FAIL starve_count: got %0d expected 32", outa.size());
        end
        for (int n = 8; n < outa.size() && n < 32; n++) begin
            checks++;
            if (outa[n] !== impulse_value(n)) begin
                errors++; $display("[TB] FAIL starve_resume[%0d]: got %0d expected %0d", n, outa[n], impulse_value(n));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int bad;
        clear_a();
        qa.push_back(Q);
        run_until(3, 0, 100);
        checks++;
        if (last_wr_a !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_pre_wr: got %b expected 1", last_wr_a);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus_a.y_out_wr_en !== 1'b0 || bus_a.y_out_din !== '0) begin
            errors++; $display("[TB] FAIL midreset_async: wr=%b din=%0d expected 0 0", bus_a.y_out_wr_en, bus_a.y_out_din);
        end
        qa.delete();
        bad = 0;
        repeat (3) begin
            step();
            if (last_wr_a !== 1'b0 || last_rd_a !== 1'b0 || last_din_a !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL midreset_hold: got %0d active cycles expected 0", bad);
        end
        reset_n = 1'b1;
        clear_a();
        push_impulse();
        run_until(40, 0, 400);
        checks++;
        if (outa.size() != 40) begin
            errors++; $display("[TB] FAIL midreset_count: got %0d expected 40", outa.size());
        end
        for (int n = 0; n < outa.size() && n < 40; n++) begin
            checks++;
            if (outa[n] !== impulse_value(n)) begin
                errors++; $display("[TB] FAIL midreset_impulse[%0d]: got %0d expected %0d", n, outa[n], impulse_value(n));
            end
        end
    endtask

    initial begin
        bus_a.x_in_empty = 1'b1;
        bus_a.x_in_dout  = '0;
        bus_a.y_out_full = 1'b0;
        bus_b.x_in_empty = 1'b1;
        bus_b.x_in_dout  = '0;
        bus_b.y_out_full = 1'b0;

        test_reset();
        test_dc();
        test_impulse();
        test_throughput();
        test_backpressure();
        test_starvation();
        test_reset_mid_burst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fir_interp.md
# fir_interp

Polyphase interpolating FIR filter: reads one quantized sample from an input FIFO and writes INTERPOLATION filtered samples to an output FIFO. It is the upsampling counterpart of the decimating FIR stage and sits on the transmit/synthesis side of the signal chain, between FIFOs, using the same quantized fixed-point format and rounding multiply as the rest of the design.

## Interface
- NUM_TAPS, 32: total prototype filter length; must be a multiple of INTERPOLATION.
- INTERPOLATION, 8: upsampling factor L; must be a power of two, at least 2.
- COEFFICIENTS, all zero: `[0:NUM_TAPS-1][DATA_SIZE-1:0]` quantized prototype taps h[0..NUM_TAPS-1].
- TAPS_PER_PHASE (localparam) = NUM_TAPS/INTERPOLATION, written T below.
- clock  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- x_in_dout  in  DATA_SIZE  input FIFO read data (show-ahead).
- x_in_empty  in  1  input FIFO empty.
- x_in_rd_en  out  1  input FIFO pop.
- y_out_full  in  1  output FIFO full.
- y_out_wr_en  out  1  output FIFO push.
- y_out_din  out  DATA_SIZE  output FIFO write data.

## Operation
- Shift register `hist[0:T-1]`: hist[0] is the newest input. It persists across inputs and is cleared only by reset.
- Output phase p (0..L-1) for the current input is y_p = Σ_{k=0..T-1} MULTIPLY_ROUNDING(hist[k], COEFFICIENTS[k*L+p]).
- Arithmetic is signed DATA_SIZE. The accumulator wraps modulo 2^DATA_SIZE; there is no saturation.
- FSM states:
  - S_IDLE: if !x_in_empty, then:
    - x_in_rd_en=1;
    - shift hist, with hist[0]←x_in_dout;
    - tap_value←x_in_dout; phase←0; k←0; sum←0;
    - go to S_MAC.
    - Otherwise stay in S_IDLE.
  - S_MAC: each cycle:
    - sum += MULTIPLY_ROUNDING(tap_value, COEFFICIENTS[k*L+phase]);
    - tap_value←hist[k+1];
    - k++;
    - when k==T-1, go to S_OUT.
  - S_OUT: if !y_out_full, then:
    - y_out_wr_en=1 and y_out_din=sum;
    - sum←0; k←0; tap_value←hist[0];
    - if phase==L-1, go to S_IDLE; else phase++ and go to S_MAC.
    - If full, hold every register.
- x_in_rd_en is asserted only in S_IDLE. y_out_wr_en is asserted only in S_OUT. Both are combinational from state and flags.
- y_out_din is 0 whenever y_out_wr_en=0, so there are no latches.
- Illegal state: go to S_IDLE with outputs deasserted.

## Timing
- Reset (reset_n low, asynchronous): state=S_IDLE; hist, sum, tap_value, k and phase are 0; x_in_rd_en=0, y_out_wr_en=0, y_out_din=0.
- No stalls:
  - rd_en at cycle 0, first wr_en at cycle T+1, successive wr_en every T+1 cycles.
  - Next rd_en at cycle 1+L*(T+1). With defaults that is 41 cycles per input, first output 5 cycles after the read.
- Stalls:
  - y_out_full stalls only in S_OUT and extends latency cycle-for-cycle; no output is dropped or duplicated.
  - x_in_empty stalls only in S_IDLE. A new input is never read while a burst is incomplete.
  - The full flag is sampled only in S_OUT; empty and full asserted simultaneously need no special handling.
- Reset mid-burst: the remaining phases are abandoned and history is cleared. The next input produces outputs as if it were the first sample.
- Per input, exactly L writes.

## Configuration
- FIR_INTERP_GAIN_EN defined: y_out_din = sum << log2(INTERPOLATION), wrapping. This compensates the 1/L energy loss of zero-stuffing.
- FIR_INTERP_GAIN_EN undefined: y_out_din = sum.
- Timing and handshakes are identical in both builds.

## Structure
- The shared globals package provides DATA_SIZE, BITS/QUANT_VAL and MULTIPLY_ROUNDING; the block must not redefine them.
- The state enum is local to the module. T and log2(L) are localparams.
- An elaboration-time check rejects a non-power-of-two INTERPOLATION or NUM_TAPS % INTERPOLATION ≠ 0.
- Single module with no sub-modules. The MAC datapath is small enough to stay inline.

## Test plan
All cases use defaults NUM_TAPS=32, L=8, T=4 and QUANT = QUANT_VAL.

- Impulse, COEFFICIENTS[j]=j*QUANT, gain off:
  - Stimulus: inputs QUANT, 0, 0, 0, 0.
  - Response: outputs 0,1,…,31 (×QUANT), then eight zeros; 40 writes in total.
- DC, all coefficients=QUANT, input constant QUANT:
  - Response: outputs ramp to 4*QUANT after the 4th input.
  - With FIR_INTERP_GAIN_EN: 32*QUANT.
- Throughput, empty=0 and full=0 continuously:
  - x_in_rd_en pulses every 41 cycles.
  - First y_out_wr_en is exactly 5 cycles after each read.
  - Writes are 5 cycles apart.
- Backpressure, y_out_full high for 20 cycles at the 3rd output:
  - No wr_en or rd_en during the hold.
  - Output values are identical to the unstalled run.
  - Write count equals 8×read count.
- Starvation, x_in_empty high for 100 cycles:
  - rd_en=0, wr_en=0, y_out_din=0 throughout.
  - History retained: the next outputs continue correctly.
- Reset mid-burst, reset_n low after 3 outputs:
  - Outputs go to 0 immediately (asynchronous).
  - After release, the impulse test reproduces 0..31 exactly.
